// File: rtl/l1_bus_unit_pkg.sv
// Shared types and constants for the L1 cache-to-bus responder.
// State encoding, one-hot size codes and line-offset helpers.
package l1_bus_unit_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WR   = 3'd1,
    ST_RD   = 3'd2,
    ST_LINE = 3'd3,
    ST_DONE = 3'd4,
    ST_HOLD = 3'd5
  } state_e;

  localparam logic [3:0] SZ_B = 4'b0001;
  localparam logic [3:0] SZ_H = 4'b0010;
  localparam logic [3:0] SZ_W = 4'b0100;
  localparam logic [3:0] SZ_D = 4'b1000;

  localparam int LINE_BEATS_DEF = 8;
  localparam int LINE_OFF_W     = $clog2(LINE_BEATS_DEF * 8);

  function automatic logic size_ok(input logic [3:0] s);
    return (s == SZ_B) || (s == SZ_H) || (s == SZ_W) || (s == SZ_D);
  endfunction

endpackage

// File: rtl/l1_bus_unit.sv
// Runs L1 write-through, single-read and line-fill requests as memory bus
// transactions; line data returns beat by beat, then completion/error.
module l1_bus_unit
  import l1_bus_unit_pkg::*;
#(
  parameter int ADDR_W     = 64,
  parameter int DATA_W     = 64,
  parameter int LINE_BEATS = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              L1_write_through_req,
  input  logic              read_req,
  input  logic              read_line_req,
  input  logic [3:0]        L1_size,
  input  logic [ADDR_W-1:0] pa,
  input  logic [DATA_W-1:0] wt_data,
  output logic [63:0]       line_data,
  output logic [10:0]       addr_count,
  output logic              line_write,
  output logic              cache_entry_write,
  output logic              trans_rdy,
  output logic              bus_error,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_size,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_ack,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_err
);

  localparam int OFF_W  = $clog2(LINE_BEATS * 8);
  localparam int BEAT_W = $clog2(LINE_BEATS);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_BEATS - 1);

  state_e              state_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [BEAT_W-1:0]   beat_q;
  logic                line_q;
  logic                err_q;

  logic [63:0]         line_data_q;
  logic [10:0]         addr_count_q;
  logic                line_write_q;
  logic                cache_entry_write_q;
  logic                trans_rdy_q;
  logic                bus_error_q;
  logic                bus_req_q;
  logic                bus_we_q;
  logic [ADDR_W-1:0]   bus_addr_q;
  logic [3:0]          bus_size_q;
  logic [DATA_W-1:0]   bus_wdata_q;

  logic [ADDR_W-1:0]   line_base_d;
  logic [ADDR_W-1:0]   beat_addr_d;

  assign line_base_d = {pa[ADDR_W-1:OFF_W], OFF_W'(0)};
  assign beat_addr_d = addr_q + ADDR_W'({beat_q, 3'b000});

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q             <= ST_IDLE;
      addr_q              <= '0;
      beat_q              <= '0;
      line_q              <= 1'b0;
      err_q               <= 1'b0;
      line_data_q         <= '0;
      addr_count_q        <= '0;
      line_write_q        <= 1'b0;
      cache_entry_write_q <= 1'b0;
      trans_rdy_q         <= 1'b0;
      bus_error_q         <= 1'b0;
      bus_req_q           <= 1'b0;
      bus_we_q            <= 1'b0;
      bus_addr_q          <= '0;
      bus_size_q          <= '0;
      bus_wdata_q         <= '0;
    end else begin
      line_write_q        <= 1'b0;
      cache_entry_write_q <= 1'b0;
      trans_rdy_q         <= 1'b0;
      bus_error_q         <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          beat_q <= '0;
          line_q <= 1'b0;
          err_q  <= 1'b0;
          if (L1_write_through_req || read_req) begin
            addr_q <= pa;
          end
          if (L1_write_through_req) begin
            if (size_ok(L1_size)) begin
              state_q     <= ST_WR;
              bus_req_q   <= 1'b1;
              bus_we_q    <= 1'b1;
              bus_addr_q  <= pa;
              bus_size_q  <= L1_size;
              bus_wdata_q <= wt_data;
            end else begin
              err_q   <= 1'b1;
              state_q <= ST_DONE;
            end
          end else if (read_line_req) begin
            addr_q      <= line_base_d;
            line_q      <= 1'b1;
            state_q     <= ST_LINE;
            bus_req_q   <= 1'b1;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= line_base_d;
            bus_size_q  <= SZ_D;
            bus_wdata_q <= '0;
          end else if (read_req) begin
            if (size_ok(L1_size)) begin
              state_q     <= ST_RD;
              bus_req_q   <= 1'b1;
              bus_we_q    <= 1'b0;
              bus_addr_q  <= pa;
              bus_size_q  <= L1_size;
              bus_wdata_q <= '0;
            end else begin
              err_q   <= 1'b1;
              state_q <= ST_DONE;
            end
          end
        end

        ST_WR, ST_RD: begin
          if (bus_req_q && bus_ack) begin
            bus_req_q <= 1'b0;
            err_q     <= bus_err;
            state_q   <= ST_DONE;
            if (state_q == ST_RD) begin
              line_data_q <= 64'(bus_rdata);
            end
          end
        end

        // One bus cycle per beat; a new request goes out in the line_write cycle.
        ST_LINE: begin
          if (!bus_req_q) begin
            bus_req_q  <= 1'b1;
            bus_addr_q <= beat_addr_d;
          end else if (bus_ack) begin
            bus_req_q <= 1'b0;
            if (bus_err) begin
              err_q   <= 1'b1;
              state_q <= ST_DONE;
            end else begin
              line_data_q  <= 64'(bus_rdata);
              addr_count_q <= 11'({beat_q, 3'b000});
              line_write_q <= 1'b1;
              beat_q       <= beat_q + BEAT_W'(1);
              if (beat_q == LAST_BEAT) begin
                state_q <= ST_DONE;
              end
            end
          end
        end

        ST_DONE: begin
          trans_rdy_q         <= 1'b1;
          bus_error_q         <= err_q;
          cache_entry_write_q <= line_q && !err_q;
          state_q             <= ST_HOLD;
        end

        // Requests are ignored here while L1 reacts to trans_rdy.
        ST_HOLD: state_q <= ST_IDLE;

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign line_data         = line_data_q;
  assign addr_count        = addr_count_q;
  assign line_write        = line_write_q;
  assign cache_entry_write = cache_entry_write_q;
  assign trans_rdy         = trans_rdy_q;
  assign bus_error         = bus_error_q;
  assign bus_req           = bus_req_q;
  assign bus_we            = bus_we_q;
  assign bus_addr          = bus_addr_q;
  assign bus_size          = bus_size_q;
  assign bus_wdata         = bus_wdata_q;

endmodule

// File: tb/tb_l1_bus_unit.sv
// Scoreboard bench for l1_bus_unit: a bus responder model plus expected
// bus cycles, line beats and completions queued at stimulus time.
module tb_l1_bus_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        L1_write_through_req, read_req, read_line_req;
  logic [3:0]  L1_size;
  logic [63:0] pa, wt_data;
  logic [63:0] line_data;
  logic [10:0] addr_count;
  logic        line_write, cache_entry_write, trans_rdy, bus_error;
  logic        bus_req, bus_we;
  logic [63:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_size;
  logic        bus_ack, bus_err;

  always #5 clk = ~clk;

  l1_bus_unit #(.ADDR_W(64), .DATA_W(64), .LINE_BEATS(8)) dut (
    .clk(clk), .rst(rst),
    .L1_write_through_req(L1_write_through_req), .read_req(read_req),
    .read_line_req(read_line_req), .L1_size(L1_size), .pa(pa), .wt_data(wt_data),
    .line_data(line_data), .addr_count(addr_count), .line_write(line_write),
    .cache_entry_write(cache_entry_write), .trans_rdy(trans_rdy), .bus_error(bus_error),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_size(bus_size),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata), .bus_err(bus_err)
  );

  typedef struct { logic we; logic [63:0] addr; logic [3:0] size; logic [63:0] wdata; } bus_t;
  typedef struct { logic [10:0] ac; logic [63:0] d; } lw_t;
  typedef struct { logic err; logic cew; logic chk_d; logic [63:0] d; } done_t;

  bus_t  exp_bus[$];
  lw_t   exp_lw[$];
  done_t exp_done[$];

  int total = 0;
  int bad   = 0;
  int lw_seen = 0;

  // Responder configuration
  int          ack_dly   = 0;
  logic        line_mode = 1'b0;
  int          err_beat  = -1;
  logic        single_err = 1'b0;
  logic [63:0] rd_val    = 64'h0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic zero_chk(input string tag);
    chk({tag, "_ld"}, line_data, 64'h0);
    chk({tag, "_ac"}, 64'(addr_count), 64'h0);
    chk({tag, "_pulses"}, {60'h0, line_write, cache_entry_write, trans_rdy, bus_error}, 64'h0);
    chk({tag, "_breq"}, {62'h0, bus_req, bus_we}, 64'h0);
    chk({tag, "_baddr"}, bus_addr, 64'h0);
    chk({tag, "_bsize"}, 64'(bus_size), 64'h0);
    chk({tag, "_bwd"}, bus_wdata, 64'h0);
  endtask

  // Bus responder: acks after ack_dly request cycles, checks the cycle it acks.
  initial begin : responder
    int   cnt;
    bus_t cap;
    bus_t e;
    logic [2:0] beat;
    cnt = 0;
    bus_ack = 1'b0; bus_err = 1'b0; bus_rdata = '0;
    cap = '{we: 1'b0, addr: 64'h0, size: 4'h0, wdata: 64'h0};
    forever begin
      @(negedge clk);
      bus_ack = 1'b0;
      bus_err = 1'b0;
      if (!bus_req || rst) begin
        cnt = 0;
      end else begin
        if (cnt == 0) cap = '{we: bus_we, addr: bus_addr, size: bus_size, wdata: bus_wdata};
        if (cnt == ack_dly) begin
          cnt = 0;
          beat = bus_addr[5:3];
          bus_ack = 1'b1;
          bus_rdata = line_mode ? 64'(beat) : rd_val;
          bus_err = line_mode ? (int'(beat) == err_beat) : single_err;
          chk("stab_addr", bus_addr, cap.addr);
          chk("stab_ctl", {59'h0, bus_we, bus_size}, {59'h0, cap.we, cap.size});
          chk("stab_wd", bus_wdata, cap.wdata);
          chk("bus_q", 64'(exp_bus.size() != 0), 64'h1);
          if (exp_bus.size() != 0) begin
            e = exp_bus.pop_front();
            chk("bus_addr", bus_addr, e.addr);
            chk("bus_we_size", {59'h0, bus_we, bus_size}, {59'h0, e.we, e.size});
            if (e.we) chk("bus_wdata", bus_wdata, e.wdata);
          end
        end else begin
          cnt++;
        end
      end
    end
  end

  // Output monitor: line beats and completions against the scoreboard.
  always @(negedge clk) begin
    lw_t   l;
    done_t d;
    if (!rst) begin
      if (line_write) begin
        lw_seen++;
        chk("lw_q", 64'(exp_lw.size() != 0), 64'h1);
        if (exp_lw.size() != 0) begin
          l = exp_lw.pop_front();
          chk("lw_ac", 64'(addr_count), 64'(l.ac));
          chk("lw_data", line_data, l.d);
        end
      end
      if (trans_rdy) begin
        chk("done_q", 64'(exp_done.size() != 0), 64'h1);
        if (exp_done.size() != 0) begin
          d = exp_done.pop_front();
          chk("done_err", 64'(bus_error), 64'(d.err));
          chk("done_cew", 64'(cache_entry_write), 64'(d.cew));
          if (d.chk_d) chk("done_data", line_data, d.d);
        end
      end else begin
        chk("idle_flags", {62'h0, bus_error, cache_entry_write}, 64'h0);
      end
    end
  end

  task automatic push_line(input logic [63:0] base, input int ebeat);
    int last;
    last = (ebeat >= 0) ? ebeat : 7;
    for (int n = 0; n <= last; n++)
      exp_bus.push_back('{we: 1'b0, addr: base + 64'(8 * n), size: 4'b1000, wdata: 64'h0});
    for (int n = 0; n < ((ebeat >= 0) ? ebeat : 8); n++)
      exp_lw.push_back('{ac: 11'(8 * n), d: 64'(n)});
    exp_done.push_back('{err: (ebeat >= 0), cew: (ebeat < 0), chk_d: 1'b0, d: 64'h0});
  endtask

  task automatic wait_done();
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      if (trans_rdy) break;
    end
    chk("done_seen", 64'(trans_rdy), 64'h1);
  endtask

  task automatic run_req(input int kind, input logic [63:0] a, input logic [3:0] sz,
                         input logic [63:0] wd);
    @(negedge clk);
    pa = a; L1_size = sz; wt_data = wd;
    L1_write_through_req = (kind == 0);
    read_req             = (kind == 1);
    read_line_req        = (kind == 2);
    wait_done();
    L1_write_through_req = 1'b0; read_req = 1'b0; read_line_req = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    L1_write_through_req = 1'b0; read_req = 1'b0; read_line_req = 1'b0;
    L1_size = 4'h0; pa = '0; wt_data = '0;
    repeat (2) @(posedge clk);
    #1 zero_chk("reset");
    @(negedge clk) rst = 1'b0;

    // Write-through, ack after 3 cycles
    ack_dly = 3; line_mode = 1'b0; single_err = 1'b0;
    exp_bus.push_back('{we: 1'b1, addr: 64'h8000_0010, size: 4'b0100, wdata: 64'hDEAD_BEEF});
    exp_done.push_back('{err: 1'b0, cew: 1'b0, chk_d: 1'b0, d: 64'h0});
    run_req(0, 64'h8000_0010, 4'b0100, 64'hDEAD_BEEF);

    // Single read, ack after 1 cycle
    ack_dly = 1; rd_val = 64'h1234;
    exp_bus.push_back('{we: 1'b0, addr: 64'h1004, size: 4'b0010, wdata: 64'h0});
    exp_done.push_back('{err: 1'b0, cew: 1'b0, chk_d: 1'b1, d: 64'h1234});
    run_req(1, 64'h1004, 4'b0010, 64'h0);

    // Write with bus error response
    ack_dly = 0; single_err = 1'b1;
    exp_bus.push_back('{we: 1'b1, addr: 64'h40, size: 4'b0001, wdata: 64'h5A});
    exp_done.push_back('{err: 1'b1, cew: 1'b0, chk_d: 1'b0, d: 64'h0});
    run_req(0, 64'h40, 4'b0001, 64'h5A);
    single_err = 1'b0;

    // Invalid sizes: no bus cycle, error completion
    exp_done.push_back('{err: 1'b1, cew: 1'b0, chk_d: 1'b0, d: 64'h0});
    run_req(0, 64'h80, 4'b0011, 64'h1);
    exp_done.push_back('{err: 1'b1, cew: 1'b0, chk_d: 1'b0, d: 64'h0});
    run_req(1, 64'h88, 4'b0000, 64'h0);

    // Full line fill, unaligned pa
    ack_dly = 1; line_mode = 1'b1; err_beat = -1;
    lw_seen = 0;
    push_line(64'h2000, -1);
    run_req(2, 64'h2038, 4'b1000, 64'h0);
    chk("line_beats", 64'(lw_seen), 64'd8);

    // Line fill with error on beat 3
    err_beat = 3; lw_seen = 0;
    push_line(64'h2000, 3);
    run_req(2, 64'h2010, 4'b1000, 64'h0);
    repeat (4) @(posedge clk);
    #1 chk("err_no_req", 64'(bus_req), 64'h0);
    chk("err_beats", 64'(lw_seen), 64'd3);
    err_beat = -1;

    // Write and line requested together: write first, line after HOLD
    ack_dly = 2; line_mode = 1'b0;
    exp_bus.push_back('{we: 1'b1, addr: 64'h3010, size: 4'b1000, wdata: 64'hCAFE});
    exp_done.push_back('{err: 1'b0, cew: 1'b0, chk_d: 1'b0, d: 64'h0});
    @(negedge clk);
    pa = 64'h3010; L1_size = 4'b1000; wt_data = 64'hCAFE;
    L1_write_through_req = 1'b1; read_line_req = 1'b1;
    wait_done();
    L1_write_through_req = 1'b0;
    line_mode = 1'b1;
    push_line(64'h3000, -1);
    @(posedge clk); #1 chk("hold_no_req", 64'(bus_req), 64'h0);
    @(posedge clk); #1 chk("post_hold_req", 64'(bus_req), 64'h1);
    chk("post_hold_addr", bus_addr, 64'h3000);
    wait_done();
    read_line_req = 1'b0;

    // Reset during beat 4 of a line fill
    ack_dly = 2; lw_seen = 0;
    push_line(64'h4000, -1);
    @(negedge clk);
    pa = 64'h4000; L1_size = 4'b1000; read_line_req = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (lw_seen >= 4) break;
    end
    chk("pre_rst_beats", 64'(lw_seen), 64'd4);
    rst = 1'b1; read_line_req = 1'b0;
    @(posedge clk); #1 zero_chk("midrst");
    exp_bus.delete(); exp_lw.delete(); exp_done.delete();
    @(negedge clk) rst = 1'b0;
    line_mode = 1'b0; rd_val = 64'h77;
    exp_bus.push_back('{we: 1'b0, addr: 64'h5008, size: 4'b1000, wdata: 64'h0});
    exp_done.push_back('{err: 1'b0, cew: 1'b0, chk_d: 1'b1, d: 64'h77});
    run_req(1, 64'h5008, 4'b1000, 64'h0);

    repeat (4) @(posedge clk);
    chk("left_bus", 64'(exp_bus.size()), 64'h0);
    chk("left_lw", 64'(exp_lw.size()), 64'h0);
    chk("left_done", 64'(exp_done.size()), 64'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
